// File: rtl/mem_pkg.sv
// Shared width derivations and response-entry layout for ram_bank and its response FIFO.
// Entry layout: rdata in bits [DW-1:0], err flag at bit DW when the error option is built.
package mem_pkg;

   localparam int RSP_RDATA_LSB = 0;

   function automatic int off_bits(input int dw);
      return $clog2(dw / 8);
   endfunction

   function automatic int idx_bits(input int dp);
      return (dp > 1) ? $clog2(dp) : 1;
   endfunction

   function automatic int rsp_err_pos(input int dw);
      return dw;
   endfunction

   function automatic int rsp_entry_w(input int dw, input bit err_en);
      return err_en ? dw + 1 : dw;
   endfunction

endpackage

// File: rtl/ram_bank_rsp_fifo2.sv
// Two-entry in-order response FIFO; head entry is held stable until popped.
module rsp_fifo2 #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic         valid_o,
   output logic [W-1:0] dout_o,
   output logic [1:0]   count_o
);

   logic [W-1:0] ent_q [2];
   logic [W-1:0] ent_d [2];
   logic         rd_ptr_q, rd_ptr_d;
   logic         wr_ptr_q, wr_ptr_d;
   logic [1:0]   cnt_q, cnt_d;

   // The producer never pushes into a full FIFO unless it pops in the same cycle.
   always_comb begin
      ent_d    = ent_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (push_i) begin
         ent_d[wr_ptr_q] = din_i;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_i) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      cnt_d = cnt_q + 2'(push_i) - 2'(pop_i);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent_q[0] <= '0;
         ent_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         ent_q[0] <= ent_d[0];
         ent_q[1] <= ent_d[1];
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign valid_o = (cnt_q != 2'd0);
   assign dout_o  = ent_q[rd_ptr_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/ram_bank.sv
// Single-port word RAM with byte-enable writes and an in-order 2-entry response FIFO.
// Optional error reporting (range check, ROM write) is built when RAM_BANK_ERR_EN is defined.
module ram_bank
   import mem_pkg::*;
#(
   parameter int DW       = 32,
   parameter int DP       = 4096,
   parameter int AW       = 32,
   parameter int ROM_MODE = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [AW-1:0]   req_addr_i,
   input  logic            req_we_i,
   input  logic [DW-1:0]   req_wdata_i,
   input  logic [DW/8-1:0] req_be_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [DW-1:0]   rsp_rdata_o
`ifdef RAM_BANK_ERR_EN
   ,
   output logic            rsp_err_o
`endif
);

   localparam int OB = off_bits(DW);
   localparam int IB = idx_bits(DP);
   localparam int XW = AW - OB;
`ifdef RAM_BANK_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   localparam int EW = rsp_entry_w(DW, ERR_EN);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid and its payload hold until that edge, and ready never depends on valid.

   logic [DW-1:0] mem_q [DP];
   logic [DW-1:0] rd_data_q, rd_data_d;
   logic          en_q, en_d;
   logic          infl_q, infl_d;
   logic          infl_we_q, infl_we_d;
   logic [XW-1:0] word_x;
   logic [IB-1:0] idx;
   logic          acc;
   logic          wr_en;
   logic          pop;
   logic [1:0]    fifo_cnt;
   logic [1:0]    occ;
   logic          push;
   logic [EW-1:0] push_ent;
   logic [EW-1:0] head;
   logic [DW-1:0] push_rdata;

   assign word_x = XW'(req_addr_i >> OB);

`ifdef RAM_BANK_ERR_EN
   logic in_range;
   logic req_err;
   logic infl_err_q, infl_err_d;

   assign in_range = (64'(word_x) < 64'(DP));
   assign idx      = IB'(word_x);
   assign req_err  = !in_range || (req_we_i && (ROM_MODE != 0));
   assign wr_en    = acc && req_we_i && (ROM_MODE == 0) && in_range;
`else
   assign idx      = IB'(word_x % XW'(DP));
   assign wr_en    = acc && req_we_i && (ROM_MODE == 0);
`endif

   assign pop         = rsp_valid_o && rsp_ready_i;
   assign occ         = fifo_cnt + 2'(infl_q);
   assign req_ready_o = en_q && ((occ < 2'd2) || pop);
   assign acc         = req_valid_i && req_ready_o;

   always_comb begin
      en_d      = 1'b1;
      infl_d    = acc;
      infl_we_d = acc ? req_we_i : infl_we_q;
      rd_data_d = (acc && !req_we_i) ? mem_q[idx] : rd_data_q;
   end

   // Storage is deliberately outside the reset domain so a reset never clears contents.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < DW / 8; b++) begin
            if (req_be_i[b]) begin
               mem_q[idx][b*8 +: 8] <= req_wdata_i[b*8 +: 8];
            end
         end
      end
      rd_data_q <= rd_data_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q      <= 1'b0;
         infl_q    <= 1'b0;
         infl_we_q <= 1'b0;
      end else begin
         en_q      <= en_d;
         infl_q    <= infl_d;
         infl_we_q <= infl_we_d;
      end
   end

`ifdef RAM_BANK_ERR_EN
   always_comb begin
      infl_err_d = acc ? req_err : infl_err_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         infl_err_q <= 1'b0;
      end else begin
         infl_err_q <= infl_err_d;
      end
   end

   assign push_rdata = (infl_we_q || infl_err_q) ? '0 : rd_data_q;
   assign push_ent   = {infl_err_q, push_rdata};
   assign rsp_err_o  = head[rsp_err_pos(DW)];
`else
   assign push_rdata = infl_we_q ? '0 : rd_data_q;
   assign push_ent   = push_rdata;
`endif

   // Every accepted request, read or write, lands in the FIFO one edge after acceptance.
   assign push = infl_q;

   rsp_fifo2 #(
      .W (EW)
   ) u_rsp_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .din_i   (push_ent),
      .pop_i   (pop),
      .valid_o (rsp_valid_o),
      .dout_o  (head),
      .count_o (fifo_cnt)
   );

   assign rsp_rdata_o = head[RSP_RDATA_LSB +: DW];

endmodule

// File: tb/tb_ram_bank.sv
// Directed bench for ram_bank: main instance, a DP=16 instance and a DP=16 ROM instance.
module tb_ram_bank;

   logic        clk;
   logic        rst;
   logic [2:0]  req_valid;
   logic [2:0]  req_ready;
   logic [31:0] req_addr;
   logic        req_we;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic [2:0]  rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata [3];
   logic [2:0]  rsp_err;

   int total;
   int bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   ram_bank #(.DW(32), .DP(4096), .AW(32), .ROM_MODE(0)) u_dut0 (
      .clk (clk), .rst (rst),
      .req_valid_i (req_valid[0]), .req_ready_o (req_ready[0]),
      .req_addr_i (req_addr), .req_we_i (req_we), .req_wdata_i (req_wdata), .req_be_i (req_be),
      .rsp_valid_o (rsp_valid[0]), .rsp_ready_i (rsp_ready), .rsp_rdata_o (rsp_rdata[0])
`ifdef RAM_BANK_ERR_EN
      , .rsp_err_o (rsp_err[0])
`endif
   );

   ram_bank #(.DW(32), .DP(16), .AW(32), .ROM_MODE(0)) u_dut1 (
      .clk (clk), .rst (rst),
      .req_valid_i (req_valid[1]), .req_ready_o (req_ready[1]),
      .req_addr_i (req_addr), .req_we_i (req_we), .req_wdata_i (req_wdata), .req_be_i (req_be),
      .rsp_valid_o (rsp_valid[1]), .rsp_ready_i (rsp_ready), .rsp_rdata_o (rsp_rdata[1])
`ifdef RAM_BANK_ERR_EN
      , .rsp_err_o (rsp_err[1])
`endif
   );

   ram_bank #(.DW(32), .DP(16), .AW(32), .ROM_MODE(1)) u_dut2 (
      .clk (clk), .rst (rst),
      .req_valid_i (req_valid[2]), .req_ready_o (req_ready[2]),
      .req_addr_i (req_addr), .req_we_i (req_we), .req_wdata_i (req_wdata), .req_be_i (req_be),
      .rsp_valid_o (rsp_valid[2]), .rsp_ready_i (rsp_ready), .rsp_rdata_o (rsp_rdata[2])
`ifdef RAM_BANK_ERR_EN
      , .rsp_err_o (rsp_err[2])
`endif
   );

`ifndef RAM_BANK_ERR_EN
   assign rsp_err = 3'b000;
`endif

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Call at a negedge; returns 1 time unit after the accepting edge.
   task automatic send(input int t, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be);
      int n;
      req_we       = we;
      req_addr     = addr;
      req_wdata    = data;
      req_be       = be;
      req_valid[t] = 1'b1;
      #1;
      n = 0;
      while (!req_ready[t] && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 20) begin
         total++;
         bad++;
         $error("FAIL send_timeout observed=%0d expected<20", n);
      end
      @(posedge clk);
      #1;
      req_valid[t] = 1'b0;
   endtask

   task automatic recv(input int t, output logic [31:0] d, output logic e);
      int n;
      @(negedge clk);
      n = 0;
      while (!rsp_valid[t] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         total++;
         bad++;
         $error("FAIL recv_timeout observed=%0d expected<20", n);
      end
      d = rsp_rdata[t];
      e = rsp_err[t];
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic        e;
      logic [31:0] v0;
      logic [31:0] bp_data [4];
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      req_valid = 3'b000;
      req_addr  = '0;
      req_we    = 1'b0;
      req_wdata = '0;
      req_be    = '0;
      rsp_ready = 1'b0;
      bp_data[0] = 32'hA0A0_0001;
      bp_data[1] = 32'hB1B1_0002;
      bp_data[2] = 32'hC2C2_0003;
      bp_data[3] = 32'hD3D3_0004;

      // Reset state and release timing
      repeat (2) @(negedge clk);
      check("rst_ready", 64'(req_ready[0]), 64'd0);
      check("rst_valid", 64'(rsp_valid[0]), 64'd0);
      check("rst_rdata", 64'(rsp_rdata[0]), 64'd0);
      check("rst_err", 64'(rsp_err[0]), 64'd0);
      rst = 1'b0;
      #1;
      check("rel_ready_before_edge", 64'(req_ready[0]), 64'd0);
      @(posedge clk);
      #1;
      check("rel_ready_after_edge", 64'(req_ready[0]), 64'd1);

      // Full-word write, then read with one-cycle response latency
      @(negedge clk);
      send(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
      recv(0, d, e);
      check("wr_rsp_data", 64'(d), 64'd0);
      @(negedge clk);
      send(0, 1'b0, 32'h10, 32'h0, 4'h0);
      check("rd_lat_acc_edge", 64'(rsp_valid[0]), 64'd0);
      @(posedge clk);
      #1;
      check("rd_lat_next_edge", 64'(rsp_valid[0]), 64'd1);
      recv(0, d, e);
      check("rd_full_word", 64'(d), 64'hDEAD_BEEF);

      // Partial byte write, then reads with and without low address bits
      @(negedge clk);
      send(0, 1'b1, 32'h10, 32'h0000_AA00, 4'h2);
      recv(0, d, e);
      check("be_wr_rsp", 64'(d), 64'd0);
      @(negedge clk);
      send(0, 1'b0, 32'h10, 32'h0, 4'h0);
      recv(0, d, e);
      check("be_rd", 64'(d), 64'hDEAD_AAEF);
      @(negedge clk);
      send(0, 1'b0, 32'h13, 32'h0, 4'h0);
      recv(0, d, e);
      check("low_bits_ignored", 64'(d), 64'hDEAD_AAEF);

      // Write immediately followed by a read of the same word, responses in order
      @(negedge clk);
      send(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF);
      send(0, 1'b0, 32'h20, 32'h0, 4'h0);
      recv(0, d, e);
      check("raw_first_is_write", 64'(d), 64'd0);
      recv(0, d, e);
      check("raw_second_is_read", 64'(d), 64'h1122_3344);

      // Fill words for the back-pressure sequence
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         send(0, 1'b1, 32'h30 + 32'(4 * i), bp_data[i], 4'hF);
         recv(0, d, e);
      end

      // Back-pressure: four reads with rsp_ready held low
      @(negedge clk);
      req_we = 1'b0;
      req_addr = 32'h30;
      req_valid[0] = 1'b1;
      #1;
      check("bp_ready_r0", 64'(req_ready[0]), 64'd1);
      @(posedge clk);
      @(negedge clk);
      req_addr = 32'h34;
      #1;
      check("bp_ready_r1", 64'(req_ready[0]), 64'd1);
      @(posedge clk);
      @(negedge clk);
      req_addr = 32'h38;
      #1;
      check("bp_ready_stall0", 64'(req_ready[0]), 64'd0);
      @(posedge clk);
      @(negedge clk);
      #1;
      check("bp_ready_stall1", 64'(req_ready[0]), 64'd0);
      check("bp_valid_held", 64'(rsp_valid[0]), 64'd1);
      check("bp_head_d0", 64'(rsp_rdata[0]), 64'(bp_data[0]));
      repeat (3) @(negedge clk);
      #1;
      check("bp_head_stable", 64'(rsp_rdata[0]), 64'(bp_data[0]));
      check("bp_ready_stall2", 64'(req_ready[0]), 64'd0);
      rsp_ready = 1'b1;
      #1;
      check("bp_ready_on_pop", 64'(req_ready[0]), 64'd1);
      @(posedge clk);
      @(negedge clk);
      req_addr = 32'h3C;
      #1;
      check("bp_ready_streaming", 64'(req_ready[0]), 64'd1);
      check("bp_head_d1", 64'(rsp_rdata[0]), 64'(bp_data[1]));
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      #1;
      check("bp_valid_d2", 64'(rsp_valid[0]), 64'd1);
      check("bp_head_d2", 64'(rsp_rdata[0]), 64'(bp_data[2]));
      @(posedge clk);
      @(negedge clk);
      #1;
      check("bp_valid_d3", 64'(rsp_valid[0]), 64'd1);
      check("bp_head_d3", 64'(rsp_rdata[0]), 64'(bp_data[3]));
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      check("bp_drained", 64'(rsp_valid[0]), 64'd0);

      // Reset with two responses pending; storage must survive
      @(negedge clk);
      send(0, 1'b0, 32'h30, 32'h0, 4'h0);
      send(0, 1'b0, 32'h34, 32'h0, 4'h0);
      @(negedge clk);
      #1;
      check("mid_rst_pending", 64'(rsp_valid[0]), 64'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 64'(rsp_valid[0]), 64'd0);
      check("mid_rst_ready", 64'(req_ready[0]), 64'd0);
      check("mid_rst_rdata", 64'(rsp_rdata[0]), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_ready", 64'(req_ready[0]), 64'd1);
      check("post_rst_no_stale", 64'(rsp_valid[0]), 64'd0);
      @(negedge clk);
      send(0, 1'b0, 32'h10, 32'h0, 4'h0);
      recv(0, d, e);
      check("post_rst_storage", 64'(d), 64'hDEAD_AAEF);

      // DP=16: byte address 0x40 is word index 16
      @(negedge clk);
      send(1, 1'b1, 32'h0, 32'hA5A5_A5A5, 4'hF);
      recv(1, d, e);
      check("dp16_wr_rsp", 64'(d), 64'd0);
      @(negedge clk);
      send(1, 1'b0, 32'h40, 32'h0, 4'h0);
      recv(1, d, e);
`ifdef RAM_BANK_ERR_EN
      check("dp16_oor_rdata", 64'(d), 64'd0);
      check("dp16_oor_err", 64'(e), 64'd1);
`else
      check("dp16_wrap_rdata", 64'(d), 64'hA5A5_A5A5);
`endif

      // ROM instance: a write must leave storage untouched
      @(negedge clk);
      send(2, 1'b0, 32'h0, 32'h0, 4'h0);
      recv(2, v0, e);
      @(negedge clk);
      send(2, 1'b1, 32'h0, 32'h1234_5678, 4'hF);
      recv(2, d, e);
      check("rom_wr_rsp", 64'(d), 64'd0);
`ifdef RAM_BANK_ERR_EN
      check("rom_wr_err", 64'(e), 64'd1);
`endif
      @(negedge clk);
      send(2, 1'b0, 32'h0, 32'h0, 4'h0);
      recv(2, d, e);
      check("rom_unchanged", 64'(d), 64'(v0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
